// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared FSM encoding and master-index helpers for the RAM port-A arbiter
package ram_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2, CLEAR = 2'd3} state_t;
  localparam int MIW = 1;
  function automatic logic [1:0] idx2oh(input logic [MIW-1:0] i);
    return i ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's request/response bus to the RAM port-A arbiter
interface ram_port_arbiter_if #(parameter int DW = 32, parameter int AW = 10);
  logic cs;
  logic we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic ack;
  modport master (output cs, we, adr, sel, dat_w, input dat_r, ack);
  modport slave (input cs, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ram_port_arbiter_rr_arb2: two-way round-robin grant with a registered last-grant pointer
module ram_port_arbiter_rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_i,
  input  logic           upd_i,
  output logic [1:0]     gnt_o,
  output logic [MIW-1:0] last_o
);
  logic last_q;
  // last_q resets to 1 so that m0 wins the first contested grant
  assign gnt_o = {req_i[1] & (~req_i[0] | ~last_q), req_i[0] & (~req_i[1] | last_q)};
  assign last_o = last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else if (upd_i) last_q <= gnt_o[1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between two masters and runs a whole-RAM clear sequencer
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int             DW      = 32,
  parameter int             SW      = DW / 8,
  parameter int             MD      = 1024,
  parameter int             AW      = $clog2(MD),
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_req_i,
  output logic               clr_busy_o,
  ram_port_arbiter_if.slave  m0_if,
  ram_port_arbiter_if.slave  m1_if,
  output logic               ram_clk_en_o,
  output logic               ram_we_o,
  output logic [AW-1:0]      ram_adr_o,
  output logic [SW-1:0]      ram_sel_o,
  output logic [DW-1:0]      ram_dat_w_o,
  input  logic [DW-1:0]      ram_dat_r_i
);
  state_t         state_q;
  logic [AW-1:0]  cnt_q;
  logic [1:0]     ack_q;
  logic           busy_q;
  logic           we_q;
  logic [AW-1:0]  adr_q;
  logic [SW-1:0]  sel_q;
  logic [DW-1:0]  dat_q;
  logic [1:0]     gnt;
  logic [MIW-1:0] last;
  logic           grant;
  assign grant = state_q == IDLE && !clr_req_i && |gnt;
  ram_port_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({m1_if.cs, m0_if.cs}),
    .upd_i  (grant),
    .gnt_o  (gnt),
    .last_o (last)
  );
  assign ram_clk_en_o = 1'b1;
  assign ram_we_o     = we_q;
  assign ram_adr_o    = adr_q;
  assign ram_sel_o    = sel_q;
  assign ram_dat_w_o  = dat_q;
  assign clr_busy_o   = busy_q;
  assign m0_if.ack    = ack_q[0];
  assign m1_if.ack    = ack_q[1];
  assign m0_if.dat_r  = ack_q[0] ? ram_dat_r_i : '0;
  assign m1_if.dat_r  = ack_q[1] ? ram_dat_r_i : '0;
  // the arbiter's last-grant pointer doubles as the owner of the in-flight access
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (clr_req_i) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= '0;
            sel_q   <= '1;
            dat_q   <= CLR_VAL;
          end else if (grant) begin
            state_q <= ACC;
            we_q    <= gnt[1] ? m1_if.we : m0_if.we;
            adr_q   <= gnt[1] ? m1_if.adr : m0_if.adr;
            sel_q   <= gnt[1] ? m1_if.sel : m0_if.sel;
            dat_q   <= gnt[1] ? m1_if.dat_w : m0_if.dat_w;
          end
        ACC: begin
          state_q <= RESP;
          we_q    <= 1'b0;
          ack_q   <= idx2oh(last);
        end
        RESP: begin
          state_q <= IDLE;
          ack_q   <= '0;
        end
        CLEAR:
          if (cnt_q == AW'(MD - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            adr_q <= cnt_q + 1'b1;
          end
      endcase
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for the RAM port-A arbiter and its clear sequencer
module tb_ram_port_arbiter;
  localparam int DW = 32, AW = 10, MD = 1024, MD2 = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic clr_req = 1'b0, clr_req2 = 1'b0;
  logic busy, busy2, clk_en, clk_en2, ram_we, ram_we2;
  logic [AW-1:0] ram_adr, ram_adr2;
  logic [3:0] ram_sel, ram_sel2;
  logic [31:0] ram_dat_w, ram_dat_w2, ram_dat_r, ram_dat_r2;
  ram_port_arbiter_if #(.DW(DW), .AW(AW)) m0_if ();
  ram_port_arbiter_if #(.DW(DW), .AW(AW)) m1_if ();
  ram_port_arbiter_if #(.DW(DW), .AW(AW)) n0_if ();
  ram_port_arbiter_if #(.DW(DW), .AW(AW)) n1_if ();
  ram_port_arbiter #(.DW(DW), .MD(MD)) dut (
    .clk(clk), .rst(rst), .clr_req_i(clr_req), .clr_busy_o(busy),
    .m0_if(m0_if), .m1_if(m1_if),
    .ram_clk_en_o(clk_en), .ram_we_o(ram_we), .ram_adr_o(ram_adr),
    .ram_sel_o(ram_sel), .ram_dat_w_o(ram_dat_w), .ram_dat_r_i(ram_dat_r)
  );
  ram_port_arbiter #(.DW(DW), .MD(MD2)) dut2 (
    .clk(clk), .rst(rst), .clr_req_i(clr_req2), .clr_busy_o(busy2),
    .m0_if(n0_if), .m1_if(n1_if),
    .ram_clk_en_o(clk_en2), .ram_we_o(ram_we2), .ram_adr_o(ram_adr2),
    .ram_sel_o(ram_sel2), .ram_dat_w_o(ram_dat_w2), .ram_dat_r_i(ram_dat_r2)
  );
  assign ram_dat_r2 = '0;
  assign n0_if.cs = 1'b0, n0_if.we = 1'b0, n0_if.adr = '0, n0_if.sel = '0, n0_if.dat_w = '0;
  assign n1_if.cs = 1'b0, n1_if.we = 1'b0, n1_if.adr = '0, n1_if.sel = '0, n1_if.dat_w = '0;

  logic [31:0] mem [0:MD-1];
  always @(posedge clk) begin
    ram_dat_r <= mem[ram_adr];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_adr][8*b +: 8] = ram_dat_w[8*b +: 8];
  end

  typedef struct {int m; logic [31:0] d; logic [31:0] mask;} exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && (m0_if.ack || m1_if.ack)) begin
      exp_t e;
      int g;
      logic [31:0] d;
      total++;
      g = m1_if.ack ? 1 : 0;
      d = g ? m1_if.dat_r : m0_if.dat_r;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack got m%0d dat=%h exp no ack", g, d);
      end else begin
        e = sbq.pop_front();
        if (g != e.m || (m0_if.ack && m1_if.ack) || ((d ^ e.d) & e.mask) != 0) begin
          bad++;
          $display("FAIL sb_ack got m%0d dat=%h both=%0b exp m%0d dat=%h mask=%h",
                   g, d, m0_if.ack && m1_if.ack, e.m, e.d, e.mask);
        end
      end
    end

  task automatic drive(input int m, input logic cs, input logic we, input int adr,
                       input logic [3:0] sel, input logic [31:0] d);
    if (m == 0) begin
      m0_if.cs = cs; m0_if.we = we; m0_if.adr = AW'(adr); m0_if.sel = sel; m0_if.dat_w = d;
    end else begin
      m1_if.cs = cs; m1_if.we = we; m1_if.adr = AW'(adr); m1_if.sel = sel; m1_if.dat_w = d;
    end
  endtask

  function automatic logic ackm(input int m);
    return m != 0 ? m1_if.ack : m0_if.ack;
  endfunction

  // called at posedge+1; returns at posedge+1 of the cycle after the ack
  task automatic xfer(input int m, input logic we, input int adr, input logic [3:0] sel,
                      input logic [31:0] d, input bit keep, output int lat);
    drive(m, 1'b1, we, adr, sel, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ackm(m) && lat < 40);
    if (!ackm(m)) begin
      total++;
      bad++;
      $display("FAIL ack_timeout m%0d adr=%0d got no ack exp ack", m, adr);
    end
    @(posedge clk);
    #1;
    if (!keep) drive(m, 1'b0, 1'b0, 0, 4'h0, 32'h0);
  endtask

  task automatic stream(input int m, input int base, input int n);
    int lat;
    for (int k = 0; k < n; k++) xfer(m, 1'b0, base + k, 4'h0, 32'h0, k < n - 1, lat);
  endtask

  task automatic run_clear(input bit d2, input int md, input bit dup);
    int n, errs, maxa;
    if (d2) clr_req2 = 1'b1; else clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req2 = 1'b0;
    clr_req = 1'b0;
    n = 0; errs = 0; maxa = 0;
    @(negedge clk);
    while ((d2 ? busy2 : busy) && n < md + 10) begin
      if ((d2 ? ram_adr2 : ram_adr) != AW'(n) || !(d2 ? ram_we2 : ram_we) ||
          (d2 ? ram_sel2 : ram_sel) != 4'hF || (d2 ? ram_dat_w2 : ram_dat_w) != 32'h0) errs++;
      if (int'(d2 ? ram_adr2 : ram_adr) > maxa) maxa = int'(d2 ? ram_adr2 : ram_adr);
      n++;
      if (dup) clr_req = (n == 100);
      @(negedge clk);
    end
    clr_req = 1'b0;
    chk(d2 ? "clr2_len" : "clr_len", n, md);
    chk(d2 ? "clr2_seq_errs" : "clr_seq_errs", errs, 0);
    chk(d2 ? "clr2_max_adr" : "clr_max_adr", maxa, md - 1);
    chk(d2 ? "clr2_we_after" : "clr_we_after", d2 ? ram_we2 : ram_we, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_adr"}, ram_adr, 0);
    chk({tag, "_sel"}, ram_sel, 0);
    chk({tag, "_datw"}, ram_dat_w, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_acks"}, {m1_if.ack, m0_if.ack}, 0);
    chk({tag, "_datr"}, m0_if.dat_r | m1_if.dat_r, 0);
    chk({tag, "_clken"}, clk_en, 1);
  endtask

  initial begin
    int lat, nz, k, blocked;
    drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    for (int i = 0; i < MD; i++) mem[i] = 32'h0;
    mem[5] = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    check_rst("reset");
    rst = 1'b0;
    // byte-select write then read-back of the merged word
    sbq.push_back('{0, 32'h0, 32'h0});
    sbq.push_back('{0, 32'h1234CCDD, 32'hFFFFFFFF});
    xfer(0, 1'b1, 5, 4'b0011, 32'hAABBCCDD, 1'b0, lat);
    chk("t1_wr_lat", lat, 3);
    xfer(0, 1'b0, 5, 4'h0, 32'h0, 1'b0, lat);
    chk("t1_rd_lat", lat, 3);
    chk("t1_mem5", mem[5], 32'h1234CCDD);
    // contested streams alternate, m0 first after reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem[10 + i] = 32'hA0A0A000 + i;
      mem[20 + i] = 32'hB0B0B000 + i;
    end
    for (int i = 0; i < 3; i++) begin
      sbq.push_back('{0, 32'hA0A0A000 + i, 32'hFFFFFFFF});
      sbq.push_back('{1, 32'hB0B0B000 + i, 32'hFFFFFFFF});
    end
    fork
      stream(0, 10, 3);
      stream(1, 20, 3);
    join
    // full clear with a stray clr_req in the middle
    for (int i = 0; i < MD; i++) mem[i] = 32'hFFFFFFFF;
    run_clear(1'b0, MD, 1'b1);
    nz = 0;
    for (int i = 0; i < MD; i++) if (mem[i] != 32'h0) nz++;
    chk("t3_nonzero_words", nz, 0);
    sbq.push_back('{0, 32'h0, 32'hFFFFFFFF});
    xfer(0, 1'b0, MD - 1, 4'h0, 32'h0, 1'b0, lat);
    // request held off during a clear
    mem[7] = 32'hDEADBEEF;
    fork
      run_clear(1'b0, MD, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #1;
        sbq.push_back('{1, 32'h0, 32'hFFFFFFFF});
        drive(1, 1'b1, 1'b0, 7, 4'h0, 32'h0);
        blocked = 0;
        k = 0;
        @(negedge clk);
        while (busy && k < 2000) begin
          if (m1_if.ack) blocked++;
          k++;
          @(negedge clk);
        end
        k = 1;
        while (!m1_if.ack && k < 20) begin
          @(negedge clk);
          k++;
        end
        chk("t4_ack_during_clear", blocked, 0);
        chk("t4_ack_lat", k, 3);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
      end
    join
    // reset while an access sits in ACC
    drive(0, 1'b1, 1'b0, 3, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_rst("t5a");
    drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    // reset at clear counter 300 leaves the RAM partially cleared
    for (int i = 0; i < MD; i++) mem[i] = 32'hFFFFFFFF;
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    k = 0;
    @(negedge clk);
    while (!(busy && ram_adr == AW'(300)) && k < 2000) begin
      k++;
      @(negedge clk);
    end
    chk("t5b_reached_300", ram_adr, 300);
    rst = 1'b1;
    @(negedge clk);
    check_rst("t5b");
    chk("t5b_mem299", mem[299], 32'h0);
    chk("t5b_mem300", mem[300], 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_clear(1'b0, MD, 1'b0);
    // non-power-of-two depth
    run_clear(1'b1, MD2, 1'b0);
    repeat (4) @(negedge clk);
    chk("sb_leftover", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
